// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle for the two sources that share the register file write port.
// Port 0 is the ALU, port 1 is the LSU/multi-cycle unit. The master side drives the
// requests, and the arbiter (slave side) returns a combinational ready for each port.
interface regfile_wb_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req0_valid;
  logic [4:0]            req0_addr;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [4:0]            req1_addr;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter for the single register file write port,
// with a 32-entry busy scoreboard. A register is reserved at issue and cleared at the
// edge where the register file takes its data.
// Optional feature macro: REGFILE_WB_ARBITER_BYPASS_EN adds forwarding outputs per query
// port. While forwarding is valid, the busy query reads 0.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int PRIO_RESET = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_wb_arbiter_if.slave   wb,
  input  logic                  rsv_valid,
  input  logic [4:0]            rsv_addr,
  input  logic [4:0]            qa_addr,
  input  logic [4:0]            qb_addr,
  output logic                  qa_busy,
  output logic                  qb_busy,
  output logic                  rf_we,
  output logic [4:0]            rf_addr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
`ifdef REGFILE_WB_ARBITER_BYPASS_EN
  output logic                  qa_fwd_valid,
  output logic                  qb_fwd_valid,
  output logic [DATA_WIDTH-1:0] qa_fwd_data,
  output logic [DATA_WIDTH-1:0] qb_fwd_data,
`endif
  output logic                  err_waw
);

  // rr_last = 1 means port 1 was granted most recently, so port 0 wins the next tie
  logic                  rr_last;
  logic                  gnt0_p0;
  logic                  gnt1_p0;
  logic                  we_p1;
  logic [4:0]            addr_p1;
  logic [DATA_WIDTH-1:0] wdata_p1;
  logic [31:0]           busy_q;
  logic [31:0]           busy_d;
  logic                  waw_hit;
  logic                  err_q;

  // Stage p0: grant decision, combinational from the valids and round-robin pointer
  always_comb begin
    gnt0_p0 = wb.req0_valid && (!wb.req1_valid || rr_last);
    gnt1_p0 = wb.req1_valid && (!wb.req0_valid || !rr_last);
  end

  assign wb.req0_ready = gnt0_p0;
  assign wb.req1_ready = gnt1_p0;

  // Round-robin pointer follows every grant; reset value lets PRIO_RESET win first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= (PRIO_RESET == 0) ? 1'b1 : 1'b0;
    end else if (gnt0_p0 || gnt1_p0) begin
      rr_last <= gnt1_p0;
    end
  end

  // Stage p1: registered write port; x0 writes are accepted but never asserted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_p1    <= 1'b0;
      addr_p1  <= 5'd0;
      wdata_p1 <= '0;
    end else if (gnt0_p0) begin
      we_p1    <= (wb.req0_addr != 5'd0);
      addr_p1  <= wb.req0_addr;
      wdata_p1 <= wb.req0_data;
    end else if (gnt1_p0) begin
      we_p1    <= (wb.req1_addr != 5'd0);
      addr_p1  <= wb.req1_addr;
      wdata_p1 <= wb.req1_data;
    end else begin
      we_p1    <= 1'b0;
    end
  end

  assign rf_we    = we_p1;
  assign rf_addr  = addr_p1;
  assign rf_wdata = wdata_p1;

  // Scoreboard next state: clear on the write edge, then reserve so reserve wins a tie.
  // A reserve landing on the very edge its old write retires is not a WAW.
  always_comb begin
    busy_d = busy_q;
    if (we_p1) begin
      busy_d[addr_p1] = 1'b0;
    end
    if (rsv_valid && (rsv_addr != 5'd0)) begin
      busy_d[rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
    waw_hit = rsv_valid && (rsv_addr != 5'd0) && busy_q[rsv_addr] &&
              !(we_p1 && (addr_p1 == rsv_addr));
  end

  // Scoreboard register and sticky WAW flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (waw_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_waw = err_q;

`ifdef REGFILE_WB_ARBITER_BYPASS_EN
  // Forwarding from the write port masks busy one cycle before the scoreboard clears
  always_comb begin
    qa_fwd_valid = we_p1 && (addr_p1 == qa_addr) && (qa_addr != 5'd0);
    qb_fwd_valid = we_p1 && (addr_p1 == qb_addr) && (qb_addr != 5'd0);
    qa_fwd_data  = wdata_p1;
    qb_fwd_data  = wdata_p1;
    qa_busy      = busy_q[qa_addr] && !qa_fwd_valid;
    qb_busy      = busy_q[qb_addr] && !qb_fwd_valid;
  end
`else
  // Busy query straight from the scoreboard
  always_comb begin
    qa_busy = busy_q[qa_addr];
    qb_busy = busy_q[qb_addr];
  end
`endif

endmodule
